// File: rtl/cpu_pkg.sv
// +------------------------------------------------------------------+
// | cpu_pkg : shared CPU datapath widths, memory FSM state encoding  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

    localparam int DATA_W         = 32;
    localparam int TIMEOUT_CYCLES = 15;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_handshake_fsm.sv
// +------------------------------------------------------------------+
// | mem_handshake_fsm : RAM req/ack sequencer with busy/done/err     |
// | Optional access timeout under macro MEM_TIMEOUT_EN               |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module mem_handshake_fsm #(
    parameter int TIMEOUT_CYCLES = cpu_pkg::TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic clr,
    input  logic read,
    input  logic write,
    input  logic mem_ack,
    output logic rd_capture,
    output logic busy,
    output logic done,
    output logic err,
    output logic mem_req,
    output logic mem_we
);

    import cpu_pkg::*;

    mem_state_t r_state;
    logic       w_accept;
    logic       w_abort;

    assign w_accept   = (r_state == IDLE) && (read || write);
    assign rd_capture = (r_state == ACCESS) && mem_ack && !mem_we;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_limit;

    assign w_limit = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    // An ack on the limit edge wins over the abort.
    assign w_abort = (r_state == ACCESS) && !mem_ack && w_limit;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_cnt <= '0;
            err   <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
            err   <= 1'b0;
        end else if ((r_state == ACCESS) && !mem_ack) begin
            if (w_limit) begin
                err <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign w_abort = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (read || write) begin
                        r_state <= ACCESS;
                        mem_req <= 1'b1;
                        busy    <= 1'b1;
                        mem_we  <= !read;
                    end
                end
                ACCESS: begin
                    if (mem_ack || w_abort) begin
                        r_state <= IDLE;
                        mem_req <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_interface.sv
// +------------------------------------------------------------------+
// | mem_interface : MAR/MDR stage between CPU bus and RAM handshake  |
// | Optional access timeout under macro MEM_TIMEOUT_EN               |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module mem_interface #(
    parameter int DATA_W         = cpu_pkg::DATA_W,
    parameter int ADDR_W         = 9,
    parameter int TIMEOUT_CYCLES = cpu_pkg::TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mar_in,
    input  logic              mdr_in,
    input  logic              read,
    input  logic              write,
    output logic [DATA_W-1:0] mdr_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    import cpu_pkg::*;

    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_mdr;
    logic              w_rd_capture;

    mem_handshake_fsm #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_fsm (
        .clk        (clk),
        .clr        (clr),
        .read       (read),
        .write      (write),
        .mem_ack    (mem_ack),
        .rd_capture (w_rd_capture),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mem_req    (mem_req),
        .mem_we     (mem_we)
    );

    // busy mirrors the ACCESS state, so strobes only load while idle.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_mar <= '0;
            r_mdr <= '0;
        end else begin
            if (!busy && mar_in) begin
                r_mar <= bus_in[ADDR_W-1:0];
            end
            if (w_rd_capture) begin
                r_mdr <= mem_rdata;
            end else if (!busy && mdr_in) begin
                r_mdr <= bus_in;
            end
        end
    end

    assign mem_addr  = r_mar;
    assign mem_wdata = r_mdr;
    assign mdr_out   = r_mdr;

endmodule

`default_nettype wire

// File: doc/mem_interface.md
# mem_interface

Memory interface stage holding the MAR and MDR. It latches address and data from the CPU bus, runs a request/acknowledge handshake to the RAM, and presents the MDR contents to the bus multiplexer's `mdr` input. The datapath control sequencer drives its load and start strobes. The block is the only path between the internal 32-bit bus and memory.

## Interface
- `DATA_W`, 32, bus and memory data width
- `ADDR_W`, 9, memory word-address width (512 words)
- `TIMEOUT_CYCLES`, 15, maximum `ACCESS` cycles without `mem_ack` (used only with `MEM_TIMEOUT_EN`)

- `clk`  in  1  single clock, rising edge
- `clr`  in  1  asynchronous, active-low reset
- `bus_in`  in  DATA_W  internal bus value
- `mar_in`  in  1  load MAR from `bus_in[ADDR_W-1:0]`
- `mdr_in`  in  1  load MDR from `bus_in`
- `read`  in  1  start memory read into MDR
- `write`  in  1  start memory write of MDR
- `mdr_out`  out  DATA_W  MDR contents, to bus mux `mdr` input
- `busy`  out  1  access in progress
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  sticky timeout flag
- `mem_addr`  out  ADDR_W  MAR contents
- `mem_wdata`  out  DATA_W  MDR contents
- `mem_req`  out  1  memory request
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req` = 1
- `mem_rdata`  in  DATA_W  read data, valid with `mem_ack`
- `mem_ack`  in  1  memory completion

## Operation
- Reset value of MAR, MDR, `mem_req`, `mem_we`, `busy`, `done`, `err`, and the timeout counter is 0. State resets to `IDLE`.
- FSM states are `IDLE` and `ACCESS`.
- **`IDLE`:**
  - `read` or `write` high at an edge → `ACCESS`.
  - `mem_we` is set to 1 for `write`, 0 for `read`.
  - `mem_req` and `busy` go to 1.
  - `err` is cleared.
- **Simultaneous `read` and `write`:** read wins and the write is dropped.
- **`ACCESS`:**
  - `mem_ack` sampled at 1 → on a read, MDR takes `mem_rdata`.
  - `mem_req` and `busy` go to 0, `done` goes to 1 for one cycle, and the FSM returns to `IDLE`.
- **Strobes in `IDLE`:**
  - `mar_in` and `mdr_in` load on the same edge that accepts `read`/`write`.
  - The access therefore uses the new MAR value and, for a write, the new MDR value ("load-and-go").
  - `mdr_in` with `read` in the same cycle: MDR loads `bus_in`, then is overwritten by `mem_rdata` at ack.
- **Strobes in `ACCESS`:** `mar_in`, `mdr_in`, `read`, and `write` are ignored. MAR and MDR stay stable for the whole access.
- **Unexpected ack:** `mem_ack` in `IDLE` is ignored.
- **Reset mid-access:** `mem_req` drops immediately (asynchronously), no `done` pulse is produced, and MDR goes to 0.

## Timing
- `mem_addr`, `mem_wdata`, and `mdr_out` are registered outputs taken directly from MAR and MDR.
- A request accepted at edge N gives `mem_req` = 1 from cycle N+1.
- Ack sampled at edge M gives:
  - `mem_req` = 0 and `done` = 1 during cycle M+1;
  - updated `mdr_out` visible in cycle M+1.
- Minimum access time: ack in the first `ACCESS` cycle gives a 2-cycle request-to-`done` latency.
- A new `read`/`write` is accepted in the same cycle that `done` = 1, which allows back-to-back accesses every 2 cycles.
- `done` is never high for two consecutive cycles.

## Configuration
- Macro `MEM_TIMEOUT_EN`.
- **Defined:**
  - The counter increments each `ACCESS` cycle without ack.
  - When it reaches `TIMEOUT_CYCLES`, the access aborts: `mem_req` = 0, `done` pulses, `err` = 1 (sticky), MDR is unchanged, and the FSM returns to `IDLE`.
  - Ack on the same edge as the limit completes normally with no error.
  - The counter clears on entry to `ACCESS`.
- **Undefined:** `ACCESS` waits indefinitely, `err` is tied to 0, and there is no counter logic.

## Structure
- Shared package `cpu_pkg` holds:
  - `DATA_W`;
  - the `mem_state_t` enum (`IDLE`, `ACCESS`);
  - the default `TIMEOUT_CYCLES`.
- Sub-module `mem_handshake_fsm` holds the state, the timeout counter, and the `busy`/`done`/`err` logic.
- The top level holds MAR, MDR, and the load muxing.

## Test plan
- **Reset:** `clr` = 0 → all outputs 0. Release, then `mar_in` with `bus_in` = 0x1F3 → `mem_addr` = 0x1F3 next cycle.
- **Read:** MAR = 0x010, `read`, ack after 3 wait cycles with `mem_rdata` = 0xDEADBEEF → `mem_we` = 0, `done` one cycle later, `mdr_out` = 0xDEADBEEF.
- **Load-and-go write:** `mdr_in`, `mar_in`, and `write` in one cycle with `bus_in` = 0x000000A5 → `mem_req` next cycle with `mem_addr` = 0x0A5, `mem_wdata` = 0x000000A5, `mem_we` = 1.
- **Ignored strobes during `ACCESS`:** `mdr_in`, `mar_in`, and `read` pulsed while busy → MAR and MDR unchanged, exactly one `done`.
- **Timeout:** with `MEM_TIMEOUT_EN` and no ack → `done` and `err` = 1 after 15 `ACCESS` cycles, MDR unchanged. The next read with ack clears `err`.
- **Mid-access reset:** `clr` asserted in `ACCESS` → `mem_req` = 0 asynchronously, no `done`, FSM in `IDLE` after release.
